// File: rtl/merlin_pfu_mo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : merlin_pfu_mo                                              |
// | Description : Instruction prefetch unit. Issues sequential ibus fetches  |
// |               under a FIFO credit scheme and an outstanding-request      |
// |               limit. Buffers the responses in a small FIFO for the       |
// |               decoder. Drops stale responses after a vector.             |
// | Ports       : clk_i/reset_i/clk_en_i - clock, sync reset, clock enable   |
// |               ireq*  - ibus request channel (valid/ready/hpl/addr)       |
// |               irsp*  - ibus response channel (in-order, rerr, data)      |
// |               ids_*  - decoder interface (dav/ack/sofid/ins/ferr/pc)     |
// |               exs_*  - vectoring interface (pc_wr/pc_din/hpl)            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module merlin_pfu_mo #(
   parameter int                C_XLEN            = 32,
   parameter int                C_FIFO_DEPTH_X    = 2,
   parameter int                C_MAX_OUTSTANDING = 2,
   parameter logic [C_XLEN-1:0] C_RESET_VECTOR    = '0,
   parameter int                C_SOFID_SZ        = 2,
   parameter int                C_SOFID_RUN       = 0,
   parameter int                C_SOFID_JUMP      = 1
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  clk_en_i,
   // ibus request
   input  logic                  ireqready_i,
   output logic                  ireqvalid_o,
   output logic [1:0]            ireqhpl_o,
   output logic [C_XLEN-1:0]     ireqaddr_o,
   // ibus response
   output logic                  irspready_o,
   input  logic                  irspvalid_i,
   input  logic                  irsprerr_i,
   input  logic [C_XLEN-1:0]     irspdata_i,
   // decoder
   output logic                  ids_dav_o,
   input  logic                  ids_ack_i,
   output logic [C_SOFID_SZ-1:0] ids_sofid_o,
   output logic [31:0]           ids_ins_o,
   output logic                  ids_ferr_o,
   output logic [C_XLEN-1:0]     ids_pc_o,
   // vectoring
   input  logic                  exs_pc_wr_i,
   input  logic [C_XLEN-1:0]     exs_pc_din_i,
   input  logic [1:0]            exs_hpl_i
);

   localparam int D    = 1 << C_FIFO_DEPTH_X;
   localparam int FAW  = C_FIFO_DEPTH_X;
   localparam int CW   = C_FIFO_DEPTH_X + 1;
   localparam int OW   = $clog2(C_MAX_OUTSTANDING + 1);
   localparam int AQW  = (C_MAX_OUTSTANDING > 1) ? $clog2(C_MAX_OUTSTANDING) : 1;
   localparam int DW   = 8;
   localparam int LSB  = $clog2(C_XLEN / 8);
   localparam int EW   = C_SOFID_SZ + 1 + C_XLEN + 32;

   localparam logic [C_XLEN-1:0]     PC_INC     = C_XLEN'(C_XLEN / 8);
   localparam logic [C_XLEN-1:0]     ALIGN_MASK = ~(C_XLEN'((1 << LSB) - 1));
   localparam logic [C_SOFID_SZ-1:0] SOF_JUMP   = C_SOFID_SZ'(C_SOFID_JUMP);
   localparam logic [C_SOFID_SZ-1:0] SOF_RUN    = C_SOFID_SZ'(C_SOFID_RUN);
   localparam logic [AQW-1:0]        AQ_LAST    = AQW'(C_MAX_OUTSTANDING - 1);

   logic [C_XLEN-1:0] pc_q;
   logic [CW-1:0]     credit_q;
   logic [OW-1:0]     outstanding_q;
   logic [DW-1:0]     discard_q;
   logic              jump_q;

   logic [C_XLEN-1:0] aq_mem [C_MAX_OUTSTANDING];
   logic [AQW-1:0]    aq_rd_q, aq_wr_q;
   logic [EW-1:0]     fifo_mem [D];
   logic [FAW:0]      f_rd_q, f_wr_q;

   logic              vec, req, rsp, drop, live, ack, fifo_empty;
   logic [DW-1:0]     inflight, vec_discard;
   logic [EW-1:0]     head, wr_entry;
   logic [AQW-1:0]    aq_rd_nxt, aq_wr_nxt;

   assign vec         = clk_en_i & exs_pc_wr_i;
   assign ireqvalid_o = clk_en_i & ~exs_pc_wr_i & (credit_q != '0)
                        & (outstanding_q < OW'(C_MAX_OUTSTANDING));
   assign req         = ireqvalid_o & ireqready_i;
   assign rsp         = clk_en_i & irspvalid_i;
   assign drop        = rsp & (discard_q != '0);
   // A response with nothing in flight is a protocol error and is ignored.
   assign live        = rsp & ~vec & (discard_q == '0) & (outstanding_q != '0);
   assign fifo_empty  = (f_rd_q == f_wr_q);
   assign ack         = clk_en_i & ids_ack_i & ~fifo_empty & ~vec;

   // Everything still on the bus at a vector is stale; a response retiring
   // in the vector cycle itself is already accounted for.
   assign inflight    = DW'(outstanding_q) + discard_q;
   assign vec_discard = (rsp && inflight != '0) ? inflight - 1'b1 : inflight;

   assign aq_rd_nxt   = (aq_rd_q == AQ_LAST) ? '0 : aq_rd_q + 1'b1;
   assign aq_wr_nxt   = (aq_wr_q == AQ_LAST) ? '0 : aq_wr_q + 1'b1;

   assign wr_entry    = {(jump_q ? SOF_JUMP : SOF_RUN), irsprerr_i,
                         aq_mem[aq_rd_q], irspdata_i[31:0]};

   assign irspready_o = clk_en_i;
   assign ireqhpl_o   = exs_hpl_i;
   assign ireqaddr_o  = pc_q & ALIGN_MASK;

   // Storage is not reset, so head fields are zeroed whenever the FIFO is empty.
   assign head        = fifo_mem[f_rd_q[FAW-1:0]];
   assign ids_dav_o   = ~fifo_empty;
   assign ids_sofid_o = ids_dav_o ? head[EW-1 -: C_SOFID_SZ] : '0;
   assign ids_ferr_o  = ids_dav_o ? head[C_XLEN+32]          : 1'b0;
   assign ids_pc_o    = ids_dav_o ? head[32 +: C_XLEN]       : '0;
   assign ids_ins_o   = ids_dav_o ? head[31:0]               : '0;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         pc_q          <= C_RESET_VECTOR;
         credit_q      <= CW'(D);
         outstanding_q <= '0;
         discard_q     <= '0;
         aq_rd_q       <= '0;
         aq_wr_q       <= '0;
         f_rd_q        <= '0;
         f_wr_q        <= '0;
         jump_q        <= 1'b1;
      end else if (vec) begin
         pc_q          <= exs_pc_din_i;
         credit_q      <= CW'(D);
         outstanding_q <= '0;
         discard_q     <= vec_discard;
         aq_rd_q       <= '0;
         aq_wr_q       <= '0;
         f_rd_q        <= '0;
         f_wr_q        <= '0;
         jump_q        <= 1'b1;
      end else begin
         if (req) begin
            pc_q    <= pc_q + PC_INC;
            aq_wr_q <= aq_wr_nxt;
         end
         case ({req, ack})
            2'b10:   credit_q <= credit_q - 1'b1;
            2'b01:   credit_q <= credit_q + 1'b1;
            default: credit_q <= credit_q;
         endcase
         case ({req, live})
            2'b10:   outstanding_q <= outstanding_q + 1'b1;
            2'b01:   outstanding_q <= outstanding_q - 1'b1;
            default: outstanding_q <= outstanding_q;
         endcase
         if (drop) begin
            discard_q <= discard_q - 1'b1;
         end
         if (live) begin
            aq_rd_q <= aq_rd_nxt;
            f_wr_q  <= f_wr_q + 1'b1;
            jump_q  <= 1'b0;
         end
         if (ack) begin
            f_rd_q <= f_rd_q + 1'b1;
         end
      end
   end

   // Data storage: write enables already exclude vector cycles.
   always_ff @(posedge clk_i) begin
      if (req) begin
         aq_mem[aq_wr_q] <= pc_q;
      end
      if (live) begin
         fifo_mem[f_wr_q[FAW-1:0]] <= wr_entry;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_merlin_pfu_mo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_merlin_pfu_mo                                           |
// | Description : Directed self-checking bench for merlin_pfu_mo with a      |
// |               simple in-order ibus responder.                            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_merlin_pfu_mo;

   logic        clk = 1'b0;
   logic        reset_i, clk_en_i;
   logic        ireqready_i, ireqvalid_o;
   logic [1:0]  ireqhpl_o;
   logic [31:0] ireqaddr_o;
   logic        irspready_o, irspvalid_i, irsprerr_i;
   logic [31:0] irspdata_i;
   logic        ids_dav_o, ids_ack_i, ids_ferr_o;
   logic [1:0]  ids_sofid_o;
   logic [31:0] ids_ins_o, ids_pc_o;
   logic        exs_pc_wr_i;
   logic [31:0] exs_pc_din_i;
   logic [1:0]  exs_hpl_i;

   int          errors = 0;
   int          checks = 0;
   int          nreq   = 0;
   int          n0;
   bit          auto_rsp = 1'b1;
   logic [31:0] err_addr = 32'hFFFF_FFFF;
   logic [31:0] pend [$];

   always #5 clk = ~clk;

   merlin_pfu_mo dut (
      .clk_i        (clk),
      .reset_i      (reset_i),
      .clk_en_i     (clk_en_i),
      .ireqready_i  (ireqready_i),
      .ireqvalid_o  (ireqvalid_o),
      .ireqhpl_o    (ireqhpl_o),
      .ireqaddr_o   (ireqaddr_o),
      .irspready_o  (irspready_o),
      .irspvalid_i  (irspvalid_i),
      .irsprerr_i   (irsprerr_i),
      .irspdata_i   (irspdata_i),
      .ids_dav_o    (ids_dav_o),
      .ids_ack_i    (ids_ack_i),
      .ids_sofid_o  (ids_sofid_o),
      .ids_ins_o    (ids_ins_o),
      .ids_ferr_o   (ids_ferr_o),
      .ids_pc_o     (ids_pc_o),
      .exs_pc_wr_i  (exs_pc_wr_i),
      .exs_pc_din_i (exs_pc_din_i),
      .exs_hpl_i    (exs_hpl_i)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // One clock: sample handshakes before the edge, update responder after it.
   task automatic cyc();
      logic        fire_req, fire_rsp;
      logic [31:0] a;
      #1;
      fire_req = ireqvalid_o & ireqready_i;
      fire_rsp = irspvalid_i & clk_en_i;
      a        = ireqaddr_o;
      @(posedge clk);
      #1;
      if (fire_rsp && pend.size() > 0) void'(pend.pop_front());
      if (fire_req) begin
         pend.push_back(a);
         nreq++;
      end
      if (auto_rsp) begin
         if (pend.size() > 0) begin
            irspvalid_i = 1'b1;
            irspdata_i  = pend[0] ^ 32'hCAFE_0000;
            irsprerr_i  = (pend[0] == err_addr);
         end else begin
            irspvalid_i = 1'b0;
            irsprerr_i  = 1'b0;
         end
      end
   endtask

   task automatic do_reset();
      reset_i     = 1'b1;
      ireqready_i = 1'b0;
      ids_ack_i   = 1'b0;
      exs_pc_wr_i = 1'b0;
      irspvalid_i = 1'b0;
      cyc();
      pend.delete();
      irspvalid_i = 1'b0;
      irsprerr_i  = 1'b0;
      reset_i     = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset_i = 1'b1; clk_en_i = 1'b1; ireqready_i = 1'b0; irspvalid_i = 1'b0;
      irsprerr_i = 1'b0; irspdata_i = '0; ids_ack_i = 1'b0; exs_pc_wr_i = 1'b0;
      exs_pc_din_i = '0; exs_hpl_i = 2'b10;

      // Reset state
      cyc(); cyc();
      chk("rst_reqvalid", ireqvalid_o, 1);
      chk("rst_reqaddr",  ireqaddr_o, 0);
      chk("rst_dav",      ids_dav_o, 0);
      chk("rst_sofid",    ids_sofid_o, 0);
      chk("rst_ins",      ids_ins_o, 0);
      chk("rst_ferr",     ids_ferr_o, 0);
      chk("rst_pc",       ids_pc_o, 0);
      chk("rst_rspready", irspready_o, 1);
      chk("hpl_pass",     ireqhpl_o, 2'b10);
      clk_en_i = 1'b0; #1;
      chk("clken0_reqvalid", ireqvalid_o, 0);
      chk("clken0_rspready", irspready_o, 0);
      clk_en_i = 1'b1;

      // Streaming: 1 request per cycle, acks every cycle
      reset_i = 1'b0; ireqready_i = 1'b1; ids_ack_i = 1'b1;
      cyc(); cyc();
      for (int k = 0; k < 5; k++) begin
         chk("strm_dav",      ids_dav_o, 1);
         chk("strm_pc",       ids_pc_o, 4 * k);
         chk("strm_sofid",    ids_sofid_o, (k == 0) ? 1 : 0);
         chk("strm_ins",      ids_ins_o, 32'hCAFE_0000 | (4 * k));
         chk("strm_reqvalid", ireqvalid_o, 1);
         chk("strm_reqaddr",  ireqaddr_o, 4 * (k + 2));
         cyc();
      end

      // Credit limit: no acks -> exactly D requests, one ack -> one more
      do_reset();
      ireqready_i = 1'b1;
      n0 = nreq;
      repeat (10) cyc();
      chk("credit_nreq4",     nreq - n0, 4);
      chk("credit_reqvalid0", ireqvalid_o, 0);
      chk("credit_head_pc",   ids_pc_o, 0);
      chk("credit_head_sof",  ids_sofid_o, 1);
      ids_ack_i = 1'b1;
      cyc();
      ids_ack_i = 1'b0;
      repeat (6) cyc();
      chk("credit_nreq5",     nreq - n0, 5);
      chk("credit_reqvalid1", ireqvalid_o, 0);
      chk("credit_head_pc2",  ids_pc_o, 4);
      chk("credit_head_sof2", ids_sofid_o, 0);

      // Protocol-error response ignored, then vector drops stale responses
      do_reset();
      auto_rsp = 1'b0;
      irspvalid_i = 1'b1; irspdata_i = 32'h1234_5678;
      cyc();
      irspvalid_i = 1'b0;
      chk("proto_dav", ids_dav_o, 0);
      chk("proto_reqvalid", ireqvalid_o, 1);
      ireqready_i = 1'b1;
      cyc(); cyc();
      ireqready_i = 1'b0; #1;
      chk("outst_limit", ireqvalid_o, 0);
      exs_pc_wr_i = 1'b1; exs_pc_din_i = 32'h100; #1;
      chk("vec_noreq", ireqvalid_o, 0);
      cyc();
      exs_pc_wr_i = 1'b0; #1;
      chk("vec_addr",     ireqaddr_o, 32'h100);
      chk("vec_reqvalid", ireqvalid_o, 1);
      ireqready_i = 1'b1; irspvalid_i = 1'b1; irspdata_i = 32'hCAFE_0000;
      cyc();
      ireqready_i = 1'b0; irspdata_i = 32'hCAFE_0004;
      chk("stale1_dav", ids_dav_o, 0);
      cyc();
      chk("stale2_dav", ids_dav_o, 0);
      irspdata_i = 32'hDEAD_0100;
      cyc();
      irspvalid_i = 1'b0;
      chk("vec_dav",   ids_dav_o, 1);
      chk("vec_pc",    ids_pc_o, 32'h100);
      chk("vec_sofid", ids_sofid_o, 1);
      chk("vec_ins",   ids_ins_o, 32'hDEAD_0100);
      chk("vec_ferr",  ids_ferr_o, 0);

      // Vector coinciding with a response and an ack
      do_reset();
      ireqready_i = 1'b1;
      cyc();
      irspvalid_i = 1'b1; irspdata_i = 32'hCAFE_0000;
      cyc();
      irspvalid_i = 1'b0;
      cyc();
      ireqready_i = 1'b0;
      chk("coin_pre_pc", ids_pc_o, 0);
      exs_pc_wr_i = 1'b1; exs_pc_din_i = 32'h200; irspvalid_i = 1'b1;
      irspdata_i = 32'hCAFE_0004; ids_ack_i = 1'b1; ireqready_i = 1'b1; #1;
      chk("coin_noreq", ireqvalid_o, 0);
      n0 = nreq;
      cyc();
      chk("coin_nreq", nreq - n0, 0);
      exs_pc_wr_i = 1'b0; ids_ack_i = 1'b0; ireqready_i = 1'b0;
      irspdata_i = 32'hCAFE_0008; #1;
      chk("coin_empty", ids_dav_o, 0);
      cyc();
      irspvalid_i = 1'b0;
      chk("coin_drop", ids_dav_o, 0);
      ireqready_i = 1'b1;
      cyc();
      ireqready_i = 1'b0; irspvalid_i = 1'b1; irspdata_i = 32'hBEEF_0200;
      cyc();
      irspvalid_i = 1'b0;
      chk("coin_dav",   ids_dav_o, 1);
      chk("coin_pc",    ids_pc_o, 32'h200);
      chk("coin_sofid", ids_sofid_o, 1);
      chk("coin_ins",   ids_ins_o, 32'hBEEF_0200);

      // Error on 2nd response, then clock-enable stall mid-stream
      do_reset();
      auto_rsp = 1'b1; err_addr = 32'h4;
      ireqready_i = 1'b1; ids_ack_i = 1'b1;
      cyc(); cyc();
      chk("err_e0_pc",   ids_pc_o, 0);
      chk("err_e0_ferr", ids_ferr_o, 0);
      cyc();
      chk("err_e1_pc",   ids_pc_o, 4);
      chk("err_e1_ferr", ids_ferr_o, 1);
      chk("err_e1_ins",  ids_ins_o, 32'hCAFE_0004);
      cyc();
      chk("err_e2_pc",   ids_pc_o, 8);
      chk("err_e2_ferr", ids_ferr_o, 0);
      clk_en_i = 1'b0;
      for (int s = 0; s < 3; s++) begin
         #1;
         chk("stall_reqvalid", ireqvalid_o, 0);
         chk("stall_rspready", irspready_o, 0);
         cyc();
         chk("stall_head_pc", ids_pc_o, 8);
         chk("stall_reqaddr", ireqaddr_o, 32'h10);
         chk("stall_dav",     ids_dav_o, 1);
      end
      clk_en_i = 1'b1;
      cyc();
      chk("resume_pc0",  ids_pc_o, 32'hC);
      chk("resume_ins0", ids_ins_o, 32'hCAFE_000C);
      chk("resume_ferr", ids_ferr_o, 0);
      cyc();
      chk("resume_pc1",   ids_pc_o, 32'h10);
      chk("resume_raddr", ireqaddr_o, 32'h18);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
